// File: rtl/evict_buf_pkg.sv
// Shared types for the L2 write-back (victim) buffer.
//   line_t  : one 256-bit cache line
//   tag_t   : line tag, address[31:EB_OFFSET_BITS]
//   entry_t : layout of one buffer entry {valid, tag, line}
//   state_t : controller states
package evict_buf_pkg;

  localparam int unsigned EB_LINE_W      = 256;
  localparam int unsigned EB_ADDR_W      = 32;
  localparam int unsigned EB_OFFSET_BITS = 5;

  typedef logic [EB_LINE_W-1:0]                line_t;
  typedef logic [EB_ADDR_W-1-EB_OFFSET_BITS:0] tag_t;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    line_t line;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ_MEM = 2'd1,
    DRAIN    = 2'd2,
    RESP     = 2'd3
  } state_t;

endpackage

// File: rtl/evict_buf_store.sv
// Entry storage for the victim buffer: circular FIFO of {valid, tag, line}.
// Macro: EVICT_BUF_FWD_EN adds the matched-line mux (hit_line_o); without it
// only the hit flag is produced.
// Ports:
//   clk, rst      clock, synchronous active-high reset (discards all entries)
//   lookup_tag_i  tag compared against every valid entry; also the push tag
//   push_i        append {lookup_tag_i, wline_i} at tail (caller ensures !full)
//   overwrite_i   replace the line of the matching entry with wline_i
//   wline_i       line for push / overwrite
//   pop_i         retire the head entry (caller ensures !empty)
//   hit_o         some valid entry matches lookup_tag_i
//   hit_line_o    line of the matching entry (forwarding build only)
//   head_tag_o, head_line_o  oldest entry, used for draining
//   full_o, empty_o          occupancy flags
module evict_buf_store
  import evict_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] lookup_tag_i,
  input  logic             push_i,
  input  logic             overwrite_i,
  input  line_t            wline_i,
  input  logic             pop_i,
  output logic             hit_o,
`ifdef EVICT_BUF_FWD_EN
  output line_t            hit_line_o,
`endif
  output logic [TAG_W-1:0] head_tag_o,
  output line_t            head_line_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  line_t            line_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic [DEPTH-1:0] match_vec;

  // Writes always coalesce onto an existing tag, so at most one bit is set.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match_vec[gi] = valid_q[gi] && (tag_q[gi] == lookup_tag_i);
  end

  assign hit_o       = |match_vec;
  assign head_tag_o  = tag_q[head_q];
  assign head_line_o = line_q[head_q];
  assign full_o      = (count_q == CNT_FULL);
  assign empty_o     = (count_q == '0);

`ifdef EVICT_BUF_FWD_EN
  // One-hot match lets a plain AND-OR replace a priority mux.
  always_comb begin
    hit_line_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (match_vec[i]) hit_line_o = hit_line_o | line_q[i];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop_i) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push_i) begin
        valid_q[tail_q] <= 1'b1;
        tag_q[tail_q]   <= lookup_tag_i;
        line_q[tail_q]  <= wline_i;
        tail_q          <= tail_q + 1'b1;
      end
      if (overwrite_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (match_vec[i]) line_q[i] <= wline_i;
        end
      end
      count_q <= count_q + {{PTR_W{1'b0}}, push_i} - {{PTR_W{1'b0}}, pop_i};
    end
  end

endmodule

// File: rtl/l2_evict_buffer.sv
// Write-back (victim) buffer between the L2 memory port and the cacheline
// adaptor. Read misses bypass queued writebacks; queued lines drain when the
// read path is idle; writes to a buffered tag coalesce in place.
// Macro: EVICT_BUF_FWD_EN -- when defined, read hits are answered from the
// buffer; when undefined, a read hit drains the buffer until the tag is gone
// and then reads memory.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   l2_read, l2_write         L2 requests, held until l2_resp
//   l2_address, l2_wdata      L2 line address / writeback line
//   l2_rdata, l2_resp         read line and one-cycle completion pulse
//   mem_read, mem_write       requests to the cacheline adaptor
//   mem_address, mem_wdata    line-aligned address / line to write
//   mem_rdata, mem_resp       adaptor data and completion pulse
// All outputs come straight from flops.
module l2_evict_buffer
  import evict_buf_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned OFFSET_BITS = EB_OFFSET_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         l2_read,
  input  logic         l2_write,
  input  logic [31:0]  l2_address,
  input  logic [255:0] l2_wdata,
  output logic [255:0] l2_rdata,
  output logic         l2_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  localparam int unsigned TAG_W = 32 - OFFSET_BITS;

  state_t      state_q, state_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  line_t       mem_wdata_q, mem_wdata_d;
  logic        l2_resp_q, l2_resp_d;
  line_t       l2_rdata_q, l2_rdata_d;

  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] head_tag;
  line_t            head_line;
  logic             hit, full, empty;
  logic             push, overwrite, pop;
`ifdef EVICT_BUF_FWD_EN
  line_t            hit_line;
`endif
  logic             unused_addr_bits;

  assign req_tag          = l2_address[31:OFFSET_BITS];
  assign unused_addr_bits = ^l2_address[OFFSET_BITS-1:0];

  evict_buf_store #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_store (
    .clk          (clk),
    .rst          (rst),
    .lookup_tag_i (req_tag),
    .push_i       (push),
    .overwrite_i  (overwrite),
    .wline_i      (l2_wdata),
    .pop_i        (pop),
    .hit_o        (hit),
`ifdef EVICT_BUF_FWD_EN
    .hit_line_o   (hit_line),
`endif
    .head_tag_o   (head_tag),
    .head_line_o  (head_line),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    l2_resp_d   = 1'b0;
    l2_rdata_d  = l2_rdata_q;
    push        = 1'b0;
    overwrite   = 1'b0;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (l2_read) begin
`ifdef EVICT_BUF_FWD_EN
          if (hit) begin
            l2_rdata_d = hit_line;
            l2_resp_d  = 1'b1;
            state_d    = RESP;
          end else begin
`else
          // Memory must not be read while a newer copy sits in the buffer.
          if (hit) begin
            mem_write_d = 1'b1;
            mem_addr_d  = {head_tag, {OFFSET_BITS{1'b0}}};
            mem_wdata_d = head_line;
            state_d     = DRAIN;
          end else begin
`endif
            mem_read_d = 1'b1;
            mem_addr_d = {req_tag, {OFFSET_BITS{1'b0}}};
            state_d    = READ_MEM;
          end
        end else if (l2_write && (hit || !full)) begin
          overwrite  = hit;
          push       = !hit;
          l2_rdata_d = '0;
          l2_resp_d  = 1'b1;
          state_d    = RESP;
        end else if (l2_write || !empty) begin
          // Full-buffer write stalls behind one drain and is retried in IDLE.
          mem_write_d = 1'b1;
          mem_addr_d  = {head_tag, {OFFSET_BITS{1'b0}}};
          mem_wdata_d = head_line;
          state_d     = DRAIN;
        end
      end
      READ_MEM: begin
        if (mem_resp) begin
          mem_read_d = 1'b0;
          l2_rdata_d = mem_rdata;
          l2_resp_d  = 1'b1;
          state_d    = RESP;
        end
      end
      DRAIN: begin
        if (mem_resp) begin
          mem_write_d = 1'b0;
          pop         = 1'b1;
          state_d     = IDLE;
        end
      end
      RESP: begin
        l2_rdata_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      l2_resp_q   <= 1'b0;
      l2_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      l2_resp_q   <= l2_resp_d;
      l2_rdata_q  <= l2_rdata_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign l2_resp     = l2_resp_q;
  assign l2_rdata    = l2_rdata_q;

endmodule

// File: tb/tb_l2_evict_buffer.sv
// Bench for l2_evict_buffer: an L2 driver pushes expected responses into
// queues; an adaptor model and an L2 monitor pop and compare them.
`timescale 1ns/1ps
module tb_l2_evict_buffer;

  localparam int MEM_LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         l2_read = 1'b0;
  logic         l2_write = 1'b0;
  logic [31:0]  l2_address = '0;
  logic [255:0] l2_wdata = '0;
  logic [255:0] l2_rdata;
  logic         l2_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;

  always #5 clk = ~clk;

  l2_evict_buffer #(.DEPTH(4), .OFFSET_BITS(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .l2_read     (l2_read),
    .l2_write    (l2_write),
    .l2_address  (l2_address),
    .l2_wdata    (l2_wdata),
    .l2_rdata    (l2_rdata),
    .l2_resp     (l2_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  typedef struct packed {
    logic         is_write;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_txn_t;

  mem_txn_t     exp_mem[$];
  logic [255:0] exp_l2[$];
  logic [255:0] mem_store [bit [31:0]];
  int checks = 0;
  int passes = 0;
  int mem_wait = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
      $display("ok   %s = %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_txn(input logic w, input logic [31:0] a, input logic [255:0] d);
    mem_txn_t t;
    t.is_write = w;
    t.addr     = a;
    t.data     = d;
    exp_mem.push_back(t);
  endtask

  // Adaptor model: answers each request MEM_LAT cycles after it appears and
  // checks it against the next expected memory transaction.
  always @(negedge clk) begin
    if (rst) begin
      mem_resp = 1'b0;
      mem_wait = 0;
    end else if (mem_resp) begin
      mem_resp = 1'b0;
      mem_wait = 0;
    end else if (mem_read || mem_write) begin
      mem_wait++;
      if (mem_wait == MEM_LAT) begin
        mem_resp = 1'b1;
        checks++;
        if (exp_mem.size() == 0) begin
          $display("FAIL mem_txn: unexpected %s addr=%h data=%h",
                   mem_write ? "write" : "read", mem_address, mem_wdata);
        end else begin
          mem_txn_t e;
          e = exp_mem.pop_front();
          if (e.is_write == mem_write && e.addr == mem_address &&
              (!e.is_write || e.data == mem_wdata)) begin
            passes++;
            $display("ok   mem_txn %s addr=%h", mem_write ? "write" : "read", mem_address);
          end else begin
            $display("FAIL mem_txn: got %s addr=%h data=%h expected %s addr=%h data=%h",
                     mem_write ? "write" : "read", mem_address, mem_wdata,
                     e.is_write ? "write" : "read", e.addr, e.data);
          end
        end
        if (mem_write) mem_store[mem_address] = mem_wdata;
        else mem_rdata = mem_store.exists(mem_address) ? mem_store[mem_address]
                                                       : {8{mem_address}};
      end
    end
  end

  // L2-side monitor.
  always @(negedge clk) begin
    if (!rst && l2_resp) begin
      checks++;
      if (exp_l2.size() == 0) begin
        $display("FAIL l2_resp: unexpected, rdata=%h", l2_rdata);
      end else begin
        logic [255:0] e;
        e = exp_l2.pop_front();
        if (l2_rdata === e) begin
          passes++;
          $display("ok   l2_resp rdata=%h", l2_rdata);
        end else begin
          $display("FAIL l2_resp: got rdata=%h expected %h", l2_rdata, e);
        end
      end
    end
  end

  task automatic l2_do(input bit is_read, input logic [31:0] addr, input logic [255:0] wdata,
                       input logic [255:0] exp_rdata, output int lat);
    exp_l2.push_back(exp_rdata);
    l2_read    = is_read;
    l2_write   = !is_read;
    l2_address = addr;
    l2_wdata   = wdata;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!l2_resp && lat < 200);
    if (!l2_resp) begin
      checks++;
      $display("FAIL l2_timeout: addr=%h got no l2_resp required within 200 cycles", addr);
    end
    @(posedge clk); #1;
    l2_read  = 1'b0;
    l2_write = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((exp_mem.size() != 0 || mem_read || mem_write) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk({name, "_drained"}, 256'(exp_mem.size()), 256'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required under 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] line_r, line_a, line_b, line_c, line_d, line_e1, line_e2, line_8000;
    logic [255:0] w [5];
    int lat;
    int seen;

    line_r    = {8{32'hDEAD_0040}};
    line_a    = {8{32'hAAAA_1000}};
    line_b    = {8{32'hBBBB_2000}};
    line_c    = {8{32'hCCCC_2000}};
    line_d    = {8{32'hDDDD_3000}};
    line_e1   = {8{32'hE1E1_4000}};
    line_e2   = {8{32'hE2E2_4100}};
    line_8000 = {8{32'h0000_8000}};
    for (int i = 0; i < 5; i++) w[i] = {8{32'h5A5A_0000 + 32'((i + 1) * 256)}};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_read", 256'(mem_read), 256'd0);
    chk("rst_mem_write", 256'(mem_write), 256'd0);
    chk("rst_l2_resp", 256'(l2_resp), 256'd0);
    chk("rst_count", 256'(dut.u_store.count_q), 256'd0);
    rst = 1'b0;

    // Reset in the middle of a drain.
    l2_do(1'b0, 32'h0000_0040, line_r, 256'd0, lat);
    seen = 0;
    while (!mem_write && seen < 20) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("drain_started", 256'(mem_write), 256'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_mem_write", 256'(mem_write), 256'd0);
    chk("midrst_mem_read", 256'(mem_read), 256'd0);
    chk("midrst_mem_address", 256'(mem_address), 256'd0);
    chk("midrst_mem_wdata", mem_wdata, 256'd0);
    chk("midrst_l2_rdata", l2_rdata, 256'd0);
    chk("midrst_count", 256'(dut.u_store.count_q), 256'd0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (mem_write || mem_read) seen++;
    end
    chk("no_drain_after_rst", 256'(seen), 256'd0);

    // Write then read hit (unaligned read address).
    exp_txn(1'b1, 32'h0000_1000, line_a);
`ifndef EVICT_BUF_FWD_EN
    exp_txn(1'b0, 32'h0000_1000, 256'd0);
`endif
    l2_do(1'b0, 32'h0000_1000, line_a, 256'd0, lat);
    chk("write_latency", 256'(lat), 256'd1);
    l2_do(1'b1, 32'h0000_1010, 256'd0, line_a, lat);
`ifdef EVICT_BUF_FWD_EN
    chk("read_hit_latency", 256'(lat), 256'd1);
`endif
    wait_drained("hit");

    // Full stall: fifth write waits for the oldest line to drain.
    for (int i = 0; i < 5; i++) exp_txn(1'b1, 32'((i + 1) * 256), w[i]);
    for (int i = 0; i < 5; i++) l2_do(1'b0, 32'((i + 1) * 256), w[i], 256'd0, lat);
    chk("full_count", 256'(dut.u_store.count_q), 256'd4);
    wait_drained("full");

    // Read miss goes ahead of queued writebacks.
    exp_txn(1'b0, 32'h0000_8000, 256'd0);
    exp_txn(1'b1, 32'h0000_4000, line_e1);
    exp_txn(1'b1, 32'h0000_4100, line_e2);
    l2_do(1'b0, 32'h0000_4000, line_e1, 256'd0, lat);
    l2_do(1'b0, 32'h0000_4100, line_e2, 256'd0, lat);
    l2_do(1'b1, 32'h0000_8000, 256'd0, line_8000, lat);
    chk("read_miss_latency", 256'(lat), 256'(MEM_LAT + 1));
    wait_drained("prio");

    // Coalescing.
    exp_txn(1'b1, 32'h0000_2000, line_c);
    l2_do(1'b0, 32'h0000_2000, line_b, 256'd0, lat);
    l2_do(1'b0, 32'h0000_2000, line_c, 256'd0, lat);
    chk("coalesce_latency", 256'(lat), 256'd1);
    chk("coalesce_count", 256'(dut.u_store.count_q), 256'd1);
    wait_drained("coalesce");

    // Read of a buffered tag.
    exp_txn(1'b1, 32'h0000_3000, line_d);
`ifndef EVICT_BUF_FWD_EN
    exp_txn(1'b0, 32'h0000_3000, 256'd0);
`endif
    l2_do(1'b0, 32'h0000_3000, line_d, 256'd0, lat);
    l2_do(1'b1, 32'h0000_3000, 256'd0, line_d, lat);
    wait_drained("fwd");

    chk("l2_queue_empty", 256'(exp_l2.size()), 256'd0);
    chk("mem_queue_empty", 256'(exp_mem.size()), 256'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
